// File: rtl/spi_frame_ctrl_if.sv
// rtl/spi_frame_ctrl_if.sv - committed-frame output bus of the SPI receive controller
// master drives the held frame, slave consumes it with frame_ready.
interface spi_frame_ctrl_if #(
   parameter int WORD_W    = 16,
   parameter int NUM_WORDS = 3
);
   logic [WORD_W*NUM_WORDS-1:0] frame_data;
   logic                        frame_valid;
   logic                        frame_ready;
   logic [NUM_WORDS-1:0]        word_sign;

   modport master (
      output frame_data,
      output frame_valid,
      output word_sign,
      input  frame_ready
   );

   modport slave (
      input  frame_data,
      input  frame_valid,
      input  word_sign,
      output frame_ready
   );
endinterface

// File: rtl/spi_frame_ctrl.sv
// rtl/spi_frame_ctrl.sv - SPI mode-0 receive controller with frame qualification
// Samples the SPI pins into clk, captures one ss window and hands complete frames to a one-entry buffer.
module spi_frame_ctrl #(
   parameter int WORD_W      = 16,
   parameter int NUM_WORDS   = 3,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              sclk,
   input  logic              mosi,
   input  logic              ss,
   spi_frame_ctrl_if.master  frm,
   output logic              overrun,
   output logic              frame_err,
   output logic              busy
);
   localparam int FRAME_BITS = WORD_W * NUM_WORDS;
   localparam int CNT_W      = $clog2(FRAME_BITS + 2);
   localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_BITS);

   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

   state_t                  state_q, state_d;
   logic [SYNC_STAGES-1:0]  sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0]  mosi_sync_q, mosi_sync_d;
   logic [SYNC_STAGES-1:0]  ss_sync_q, ss_sync_d;
   logic                    sclk_prev_q, ss_prev_q;
   logic                    live_q, armed_q, armed_d;
   logic [FRAME_BITS-1:0]   shift_q, shift_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [FRAME_BITS-1:0]   data_q, data_d;
   logic [NUM_WORDS-1:0]    sign_q, sign_d, frame_sign;
   logic                    valid_q, valid_d;
   logic                    overrun_q, overrun_d;
   logic                    frame_err_q, frame_err_d;

   logic sclk_s, mosi_s, ss_s, sclk_rise, ss_rise, ss_fall;

   assign sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
   assign mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
   assign ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss};
   assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
   assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
   assign ss_s        = ss_sync_q[SYNC_STAGES-1];
   assign sclk_rise   = sclk_s & ~sclk_prev_q;
   assign ss_rise     = ss_s & ~ss_prev_q;
   assign ss_fall     = ~ss_s & ss_prev_q;

   // Only arm once a real high sample of ss has been seen, so ss held low across reset release is not a start.
   assign armed_d = armed_q | (live_q & ss_sync_q[0]);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= IDLE;
         sclk_sync_q <= '0;
         mosi_sync_q <= '0;
         ss_sync_q   <= '1;
         sclk_prev_q <= 1'b0;
         ss_prev_q   <= 1'b1;
         live_q      <= 1'b0;
         armed_q     <= 1'b0;
         shift_q     <= '0;
         cnt_q       <= '0;
         data_q      <= '0;
         sign_q      <= '0;
         valid_q     <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sclk_sync_q <= sclk_sync_d;
         mosi_sync_q <= mosi_sync_d;
         ss_sync_q   <= ss_sync_d;
         sclk_prev_q <= sclk_s;
         ss_prev_q   <= ss_s;
         live_q      <= 1'b1;
         armed_q     <= armed_d;
         shift_q     <= shift_d;
         cnt_q       <= cnt_d;
         data_q      <= data_d;
         sign_q      <= sign_d;
         valid_q     <= valid_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (ss_fall && armed_q) state_d = SHIFT;
         SHIFT:   if (ss_rise) state_d = COMMIT;
         COMMIT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      frame_sign = '0;
      for (int k = 0; k < NUM_WORDS; k++) begin
         frame_sign[k] = shift_q[(k+1)*WORD_W-1];
      end
   end

   always_comb begin
      shift_d     = shift_q;
      cnt_d       = cnt_q;
      data_d      = data_q;
      sign_d      = sign_q;
      valid_d     = valid_q & ~frm.frame_ready;
      overrun_d   = 1'b0;
      frame_err_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (ss_fall && armed_q) begin
               shift_d = '0;
               cnt_d   = '0;
            end
         end
         SHIFT: begin
            // Counter runs one past the frame length so over-long frames stay distinguishable.
            if (sclk_rise) begin
               if (cnt_q < FRAME_CNT) begin
                  shift_d = {shift_q[FRAME_BITS-2:0], mosi_s};
                  cnt_d   = cnt_q + CNT_W'(1);
               end else if (cnt_q == FRAME_CNT) begin
                  cnt_d   = cnt_q + CNT_W'(1);
               end
            end
         end
         COMMIT: begin
            if (cnt_q == FRAME_CNT) begin
               if (!valid_q || frm.frame_ready) begin
                  data_d  = shift_q;
                  sign_d  = frame_sign;
                  valid_d = 1'b1;
               end else begin
                  overrun_d = 1'b1;
               end
            end else begin
               frame_err_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      busy = (state_q == SHIFT);
   end

   assign frm.frame_data  = data_q;
   assign frm.frame_valid = valid_q;
   assign frm.word_sign   = sign_q;
   assign overrun         = overrun_q;
   assign frame_err       = frame_err_q;
endmodule

// File: tb/tb_spi_frame_ctrl.sv
// tb/tb_spi_frame_ctrl.sv - directed bench for spi_frame_ctrl with a frame scoreboard
module tb_spi_frame_ctrl;
   localparam int W  = 16;
   localparam int N  = 3;
   localparam int FB = W * N;

   logic clk    = 1'b0;
   logic resetn = 1'b0;
   logic sclk   = 1'b0;
   logic mosi   = 1'b0;
   logic ss     = 1'b1;
   logic overrun, frame_err, busy;

   int total  = 0;
   int bad    = 0;
   int ov_cnt = 0;
   int fe_cnt = 0;
   int ov0, fe0;
   logic [FB-1:0] sb_q[$];
   logic [FB-1:0] fx, fy;

   spi_frame_ctrl_if #(.WORD_W(W), .NUM_WORDS(N)) frm ();

   spi_frame_ctrl #(.WORD_W(W), .NUM_WORDS(N), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .sclk      (sclk),
      .mosi      (mosi),
      .ss        (ss),
      .frm       (frm),
      .overrun   (overrun),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [N-1:0] sign_of(input logic [FB-1:0] d);
      return {d[47], d[31], d[15]};
   endfunction

   always @(negedge clk) begin
      if (resetn) begin
         if (overrun === 1'b1) ov_cnt++;
         if (frame_err === 1'b1) fe_cnt++;
         if (frm.frame_valid === 1'b1 && frm.frame_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
               total++;
               bad++;
               $error("FAIL unexpected_frame observed=%0h expected=none", frm.frame_data);
            end else begin
               logic [FB-1:0] e;
               e = sb_q.pop_front();
               chk("frame_data", 64'(frm.frame_data), 64'(e));
               chk("word_sign", 64'(frm.word_sign), 64'(sign_of(e)));
            end
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic clk_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic spi_bits(input logic [63:0] d, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         mosi = d[i];
         clk_n(4);
         sclk = 1'b1;
         clk_n(4);
         sclk = 1'b0;
      end
   endtask

   task automatic ss_begin();
      @(negedge clk);
      ss = 1'b0;
      clk_n(4);
   endtask

   task automatic ss_end();
      clk_n(3);
      ss = 1'b1;
   endtask

   task automatic send_frame(input logic [FB-1:0] d);
      ss_begin();
      spi_bits(64'(d), FB);
      ss_end();
      clk_n(10);
   endtask

   task automatic set_ready(input logic r);
      @(posedge clk);
      #1 frm.frame_ready = r;
   endtask

   initial begin
      frm.frame_ready = 1'b0;
      clk_n(3);
      resetn = 1'b1;
      clk_n(2);

      chk("rst_valid", 64'(frm.frame_valid), 64'd0);
      chk("rst_data", 64'(frm.frame_data), 64'd0);
      chk("rst_sign", 64'(frm.word_sign), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_overrun", 64'(overrun), 64'd0);
      chk("rst_frame_err", 64'(frame_err), 64'd0);

      // short (20) and long (49) frames
      set_ready(1'b1);
      ov0 = ov_cnt; fe0 = fe_cnt;
      ss_begin(); spi_bits(64'hABCDE, 20); ss_end(); clk_n(10);
      ss_begin(); spi_bits(64'h1_5555_AAAA_0F0F, 49); ss_end(); clk_n(10);
      chk("err_pulses", 64'(fe_cnt - fe0), 64'd2);
      chk("err_no_overrun", 64'(ov_cnt - ov0), 64'd0);
      chk("err_valid", 64'(frm.frame_valid), 64'd0);
      chk("err_data", 64'(frm.frame_data), 64'd0);

      // basic frame and latency from ss rise
      ov0 = ov_cnt; fe0 = fe_cnt;
      fx = 48'h1234_8001_FFFF;
      sb_q.push_back(fx);
      ss_begin();
      spi_bits(64'(fx[47:24]), 24);
      chk("busy_mid", 64'(busy), 64'd1);
      spi_bits(64'(fx[23:0]), 24);
      clk_n(3);
      ss = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("lat_early", 64'(frm.frame_valid), 64'd0);
      @(posedge clk);
      @(negedge clk);
      chk("lat_valid", 64'(frm.frame_valid), 64'd1);
      chk("basic_sign", 64'(frm.word_sign), 64'h3);
      chk("basic_data", 64'(frm.frame_data), 64'h1234_8001_FFFF);
      clk_n(10);
      chk("basic_pulses", 64'((ov_cnt - ov0) + (fe_cnt - fe0)), 64'd0);
      chk("basic_drained", 64'(frm.frame_valid), 64'd0);

      // overrun: ready low, two good frames
      set_ready(1'b0);
      ov0 = ov_cnt;
      fx = 48'h0F0F_7777_1357;
      sb_q.push_back(fx);
      send_frame(fx);
      send_frame(48'hDEAD_BEEF_CAFE);
      chk("ovr_pulse", 64'(ov_cnt - ov0), 64'd1);
      chk("ovr_valid", 64'(frm.frame_valid), 64'd1);
      chk("ovr_kept", 64'(frm.frame_data), 64'(fx));
      set_ready(1'b1);
      @(negedge clk);
      @(negedge clk);
      chk("ovr_drop", 64'(frm.frame_valid), 64'd0);

      // accept on the same cycle as a new commit
      set_ready(1'b0);
      ov0 = ov_cnt;
      fx = 48'hAAAA_5555_C3C3;
      fy = 48'h0001_0002_0003;
      sb_q.push_back(fx);
      send_frame(fx);
      sb_q.push_back(fy);
      ss_begin();
      spi_bits(64'(fy), FB);
      clk_n(3);
      ss = 1'b1;
      repeat (3) @(posedge clk);
      #1 frm.frame_ready = 1'b1;
      @(posedge clk);
      #1 frm.frame_ready = 1'b0;
      @(negedge clk);
      chk("same_valid", 64'(frm.frame_valid), 64'd1);
      chk("same_data", 64'(frm.frame_data), 64'h0001_0002_0003);
      chk("same_no_overrun", 64'(ov_cnt - ov0), 64'd0);
      set_ready(1'b1);
      clk_n(3);
      chk("same_drained", 64'(frm.frame_valid), 64'd0);

      // reset mid-frame with ss still low at release
      ov0 = ov_cnt; fe0 = fe_cnt;
      ss_begin();
      spi_bits(64'h2_AAAA_5555, 30);
      resetn = 1'b0;
      clk_n(3);
      resetn = 1'b1;
      clk_n(5);
      chk("rmid_busy", 64'(busy), 64'd0);
      chk("rmid_valid", 64'(frm.frame_valid), 64'd0);
      clk_n(3);
      ss = 1'b1;
      clk_n(10);
      chk("rmid_idle", 64'(busy), 64'd0);
      fx = 48'h7FFF_0000_8000;
      sb_q.push_back(fx);
      send_frame(fx);
      chk("rmid_pulses", 64'((ov_cnt - ov0) + (fe_cnt - fe0)), 64'd0);

      // sclk toggling while ss is high
      fe0 = fe_cnt;
      for (int i = 0; i < 10; i++) begin
         mosi = 1'($urandom_range(0, 1));
         clk_n(4);
         sclk = 1'b1;
         clk_n(4);
         sclk = 1'b0;
      end
      clk_n(5);
      chk("idle_busy", 64'(busy), 64'd0);
      fx = 48'hA5A5_0F0F_C3C3;
      sb_q.push_back(fx);
      send_frame(fx);
      chk("idle_no_err", 64'(fe_cnt - fe0), 64'd0);

      clk_n(5);
      chk("sb_empty", 64'(sb_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/spi_frame_ctrl.md
Name: spi_frame_ctrl

Overview:
Receive-side controller for the MCU-to-FPGA SPI link. It samples the asynchronous SPI pins in the system clock domain and sequences bit and word capture. It qualifies each chip-select window as a complete or malformed frame. Complete frames of NUM_WORDS signed words go to the physics core through a one-entry valid/ready holding buffer, with overrun and framing error reporting.

Parameters:
WORD_W, 16, bits per word (int16_t from MCU)
NUM_WORDS, 3, words per frame
SYNC_STAGES, 2, flip-flop stages on sclk/mosi/ss synchronizers (>=2)

Ports:
clk  input  1  system clock; all logic on posedge
resetn  input  1  asynchronous active-low reset
sclk  input  1  SPI clock, mode 0, asynchronous to clk
mosi  input  1  SPI data, MSB first
ss  input  1  slave select, active-low, asynchronous
frame_data  output  WORD_W*NUM_WORDS  committed frame; first-received word in MSBs
frame_valid  output  1  frame_data holds an unconsumed frame
frame_ready  input  1  consumer accepts frame when frame_valid & frame_ready
word_sign  output  NUM_WORDS  sign bit of each committed word (bit NUM_WORDS-1 = first word)
overrun  output  1  one-cycle pulse: complete frame dropped, buffer full
frame_err  output  1  one-cycle pulse: frame discarded, bit count != WORD_W*NUM_WORDS
busy  output  1  high while a frame is being received (state SHIFT)

Behaviour:
- Reset (async assert, sync release): all synchronizers cleared to idle values (sclk=0, ss=1). Shift register and bit counter are 0. frame_data=0, frame_valid=0, word_sign=0, overrun=0, frame_err=0, busy=0, state IDLE.
- Synchronizers: SYNC_STAGES flops per pin. One extra flop on synced sclk and synced ss feeds edge detection.
- sclk rising edge = synced sclk 1 now, 0 previous cycle.
- Supported rate: sclk period >= 4 clk cycles. Each sclk high and low phase >= 2 clk.
- FSM IDLE:
  - ss falling edge -> SHIFT; bit counter cleared; shift register cleared.
  - sclk edges while ss high are ignored.
- FSM SHIFT:
  - Each sclk rising edge shifts synced mosi into the LSB and increments the bit counter.
  - The bit counter saturates at WORD_W*NUM_WORDS+1; bits beyond the frame length are not shifted.
  - busy=1.
- ss rising edge in SHIFT -> COMMIT, one cycle; then IDLE.
- COMMIT with count == WORD_W*NUM_WORDS:
  - If buffer empty, or frame_valid & frame_ready this cycle: load frame_data and word_sign; frame_valid=1 next cycle.
  - Else: drop the new frame, keep the old one, pulse overrun.
- COMMIT with any other count (short or long frame): discard, pulse frame_err; buffer untouched.
- ss falling edge while in COMMIT: not possible; COMMIT lasts 1 cycle, and ss high time is >= 2 clk as required of the master.
- Latency: frame_valid rises SYNC_STAGES+2 clk after the ss pin rising edge.
- Handshake:
  - frame_valid clears on the cycle after frame_valid & frame_ready, unless a COMMIT loads in that same cycle; then it stays 1 with new data.
  - frame_data is stable while frame_valid=1 and not accepted.
- word_sign[i] = MSB of word i of committed frame_data. It updates only on a successful load.
- Reset asserted mid-frame: partial frame is lost, no pulses. After release the FSM waits in IDLE for a fresh ss falling edge. If ss is already low at release, it is not treated as a frame start.
- No arithmetic beyond the counter. Words are passed through as raw two's-complement bit patterns.

Test Plan:
- Frame words 0x1234, 0x8001, 0xFFFF, sclk=clk/8 -> frame_data=0x12348001FFFF, frame_valid=1 at SYNC_STAGES+2 clk after ss rise, word_sign=3'b011, no pulses.
- frame_ready held low, send two good frames -> first frame retained, one overrun pulse, frame_valid stays 1. Raise frame_ready -> frame_valid drops the next cycle.
- ss deasserted after 20 bits, then after 49 bits -> frame_err pulses twice, frame_valid stays 0, frame_data stays 0.
- frame_valid=1 with frame_ready=1 exactly on the COMMIT cycle of frame 0x000100020003 -> no overrun, frame_valid stays 1, frame_data=0x000100020003.
- Assert resetn low after 30 bits, release, send full frame 0x7FFF00008000 -> only this frame is delivered, word_sign=3'b001.
- sclk toggling with ss high, then a normal frame -> idle toggles ignored, frame decodes correctly.
